// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding,
// default reset PC, fetch FSM states and the IF/ID register layout.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // FETCH: request outstanding; HOLD: word buffered, no request;
  // DRAIN: a killed request is still outstanding and its data will be dropped.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble has priority over load; otherwise it holds.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t data_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // Pipeline register: reset/bubble to NOP, load new entry, or hold.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (rst) begin
      q_q <= '{instr: BUBBLE_INSTR, pc: 32'h0, pcplus4: 32'h0, valid: 1'b0};
    end else if (bubble_i) begin
      q_q <= '{instr: BUBBLE_INSTR, pc: 32'h0, pcplus4: 32'h0, valid: 1'b0};
    end else if (load_i) begin
      q_q <= data_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM (FETCH/HOLD/DRAIN),
// stall buffer and redirect register, feeding the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PC_F,
  input  logic                 stall_F,
  input  logic                 flush_D,
  fetch_stage_if.master        imem,
  output logic [31:0]          PC,
  output logic [31:0]          PCnext,
  output logic [31:0]          instr_D,
  output logic [31:0]          PC_D,
  output logic [31:0]          PCplus4_D,
  output logic                 valid_D
);

  import riscv_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  pc_plus4;
  logic         ifid_load;
  logic         ifid_bubble;
  if_id_t       ifid_data;
  if_id_t       ifid_q;

  assign pc_plus4 = pc_q + 32'd4;

  // State, PC, stall buffer and redirect register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the single-word buffer and redirect register are plain flops,
    // so they are reset to known values like the rest of the state.
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
      redir_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      redir_q <= redir_d;
    end
  end

  // Next-state and IF/ID control; flush beats stall beats normal advance.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    redir_d     = redir_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_data   = '{instr: imem.imem_rdata, pc: pc_q, pcplus4: pc_plus4, valid: 1'b1};

    unique case (state_q)
      FETCH: begin
        if (flush_D) begin
          ifid_bubble = 1'b1;
          if (imem.imem_ready) begin
            pc_d = align_pc(PC_F);
          end else begin
            redir_d = align_pc(PC_F);
            state_d = DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (stall_F) begin
            buf_d   = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = align_pc(PC_F);
          end
        end else if (!stall_F) begin
          ifid_bubble = 1'b1;
        end
      end

      HOLD: begin
        if (flush_D) begin
          ifid_bubble = 1'b1;
          pc_d        = align_pc(PC_F);
          state_d     = FETCH;
        end else if (!stall_F) begin
          ifid_load       = 1'b1;
          ifid_data.instr = buf_q;
          pc_d            = align_pc(PC_F);
          state_d         = FETCH;
        end
      end

      DRAIN: begin
        // A flush while draining replaces the pending target.
        if (flush_D) begin
          redir_d = align_pc(PC_F);
        end
        if (imem.imem_ready) begin
          pc_d    = flush_D ? align_pc(PC_F) : redir_q;
          state_d = FETCH;
        end
        ifid_bubble = flush_D || !stall_F;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .data_i   (ifid_data),
    .q_o      (ifid_q)
  );

  // No request in HOLD or while reset is asserted; address is always the PC.
  assign imem.imem_req  = !rst && (state_q != HOLD);
  assign imem.imem_addr = pc_q;

  assign PC        = pc_q;
  assign PCnext    = pc_plus4;
  assign instr_D   = ifid_q.instr;
  assign PC_D      = ifid_q.pc;
  assign PCplus4_D = ifid_q.pcplus4;
  assign valid_D   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, a behavioural
// reference model compared every cycle, and hand-computed spot checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_F;
  logic        stall_F;
  logic        flush_D;
  logic [31:0] PC, PCnext, instr_D, PC_D, PCplus4_D;
  logic        valid_D;

  logic        ready_v;
  logic        follow_next;
  logic [31:0] pcf_val;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PC_F      (PC_F),
    .stall_F   (stall_F),
    .flush_D   (flush_D),
    .imem      (imem),
    .PC        (PC),
    .PCnext    (PCnext),
    .instr_D   (instr_D),
    .PC_D      (PC_D),
    .PCplus4_D (PCplus4_D),
    .valid_D   (valid_D)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a recognisable word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  assign imem.imem_ready = ready_v;
  assign imem.imem_rdata = ready_v ? mem_word(imem.imem_addr) : 32'hDEAD_BEEF;
  assign PC_F            = follow_next ? PCnext : pcf_val;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_redir, m_buf;
  logic        m_buffered;   // a fetched word is parked, no request out
  logic        m_killed;     // an outstanding request's data must be dropped
  logic [31:0] m_instr, m_pcd, m_pc4d;
  logic        m_valid;

  task automatic m_bubble();
    m_instr = 32'h0000_0013;
    m_pcd   = 32'h0;
    m_pc4d  = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic m_deliver(input logic [31:0] word);
    m_instr = word;
    m_pcd   = m_pc;
    m_pc4d  = m_pc + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_redir    = 32'h0;
    m_buf      = 32'h0;
    m_buffered = 1'b0;
    m_killed   = 1'b0;
    m_bubble();
  endtask

  task automatic model_step();
    logic [31:0] target;
    target = {PC_F[31:2], 2'b00};
    if (m_buffered) begin
      if (flush_D) begin
        m_bubble();
        m_pc = target;
        m_buffered = 1'b0;
      end else if (!stall_F) begin
        m_deliver(m_buf);
        m_pc = target;
        m_buffered = 1'b0;
      end
    end else if (m_killed) begin
      if (flush_D) m_redir = target;
      if (flush_D || !stall_F) m_bubble();
      if (ready_v) begin
        m_pc = m_redir;
        m_killed = 1'b0;
      end
    end else begin
      if (flush_D) begin
        m_bubble();
        if (ready_v) m_pc = target;
        else begin
          m_redir = target;
          m_killed = 1'b1;
        end
      end else if (ready_v) begin
        if (stall_F) begin
          m_buf = mem_word(m_pc);
          m_buffered = 1'b1;
        end else begin
          m_deliver(mem_word(m_pc));
          m_pc = target;
        end
      end else if (!stall_F) begin
        m_bubble();
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("m_imem_req", {31'h0, imem.imem_req}, {31'h0, !m_buffered && !rst});
      check("m_imem_addr", imem.imem_addr, m_pc);
      check("m_PC", PC, m_pc);
      check("m_PCnext", PCnext, m_pc + 32'd4);
      check("m_instr_D", instr_D, m_instr);
      check("m_PC_D", PC_D, m_pcd);
      check("m_PCplus4_D", PCplus4_D, m_pc4d);
      check("m_valid_D", {31'h0, valid_D}, {31'h0, m_valid});
    end
  end

  // Drive one cycle of inputs just after a negedge; return at the next negedge.
  task automatic apply(input logic r, input logic s, input logic f,
                       input logic fol, input logic [31:0] pcf);
    #1;
    ready_v     = r;
    stall_F     = s;
    flush_D     = f;
    follow_next = fol;
    pcf_val     = pcf;
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic [31:0] pcf;
  } vec_t;

  vec_t vecs[16];

  initial begin
    rst = 1'b1;
    ready_v = 1'b0; stall_F = 1'b0; flush_D = 1'b0;
    follow_next = 1'b1; pcf_val = 32'h0;
    vecs = '{
      '{1'b1, 1'b0, 1'b0, 32'h20}, '{1'b1, 1'b1, 1'b0, 32'h24},
      '{1'b0, 1'b1, 1'b0, 32'h28}, '{1'b1, 1'b1, 1'b0, 32'h2C},
      '{1'b0, 1'b1, 1'b1, 32'h40}, '{1'b0, 1'b1, 1'b0, 32'h44},
      '{1'b0, 1'b0, 1'b0, 32'h44}, '{1'b0, 1'b1, 1'b1, 32'h50},
      '{1'b0, 1'b1, 1'b0, 32'h60}, '{1'b1, 1'b1, 1'b0, 32'h60},
      '{1'b1, 1'b0, 1'b0, 32'h54}, '{1'b1, 1'b1, 1'b0, 32'h58},
      '{1'b1, 1'b0, 1'b1, 32'h70}, '{0, 1'b0, 1'b1, 32'h80},
      '{1'b1, 1'b0, 1'b1, 32'h90}, '{1'b1, 1'b0, 1'b0, 32'h95}
    };

    @(negedge clk);
    @(negedge clk);
    check("rst_PC", PC, 32'h0);
    check("rst_instr_D", instr_D, 32'h0000_0013);
    check("rst_valid_D", {31'h0, valid_D}, 32'h0);
    check("rst_imem_req", {31'h0, imem.imem_req}, 32'h0);

    #1 rst = 1'b0;
    #1 check("first_addr", imem.imem_addr, 32'h0);

    // Streaming fetch with PC_F = PCnext.
    apply(1, 0, 0, 1, 0);
    check("s1_addr", imem.imem_addr, 32'h4);
    check("s1_instr", instr_D, 32'hA500_0000);
    check("s1_PC_D", PC_D, 32'h0);
    check("s1_PCp4", PCplus4_D, 32'h4);
    check("s1_valid", {31'h0, valid_D}, 32'h1);
    apply(1, 0, 0, 1, 0);
    check("s2_addr", imem.imem_addr, 32'h8);
    check("s2_instr", instr_D, 32'hA500_0004);

    // Stall while the word at 0x8 returns: buffered, request dropped.
    apply(1, 1, 0, 1, 0);
    check("hold_req", {31'h0, imem.imem_req}, 32'h0);
    check("hold_PC", PC, 32'h8);
    check("hold_instr", instr_D, 32'hA500_0004);
    apply(1, 0, 0, 1, 0);
    check("unhold_instr", instr_D, 32'hA500_0008);
    check("unhold_PC_D", PC_D, 32'h8);
    check("unhold_PC", PC, 32'hC);
    apply(1, 0, 0, 1, 0);
    check("s5_PC", PC, 32'h10);

    // Flush while the request at 0x10 is outstanding.
    apply(0, 0, 1, 0, 32'h100);
    check("drain_addr", imem.imem_addr, 32'h10);
    check("drain_req", {31'h0, imem.imem_req}, 32'h1);
    check("drain_valid", {31'h0, valid_D}, 32'h0);
    apply(1, 0, 0, 0, 32'h100);
    check("redir_addr", imem.imem_addr, 32'h100);
    check("redir_valid", {31'h0, valid_D}, 32'h0);
    check("redir_instr", instr_D, 32'h0000_0013);
    apply(1, 0, 0, 1, 0);
    check("s8_instr", instr_D, 32'hA500_0100);
    check("s8_PC_D", PC_D, 32'h100);

    // Stall and flush together: flush wins.
    apply(1, 1, 1, 0, 32'h200);
    check("sf_valid", {31'h0, valid_D}, 32'h0);
    check("sf_instr", instr_D, 32'h0000_0013);
    check("sf_PC", PC, 32'h200);

    // Wrap and alignment.
    apply(1, 0, 0, 0, 32'hFFFF_FFFC);
    check("wrap_PC", PC, 32'hFFFF_FFFC);
    check("wrap_PCnext", PCnext, 32'h0);
    apply(1, 0, 0, 0, 32'h103);
    check("align_PC", PC, 32'h100);
    check("wrap_instr", instr_D, 32'h5AFF_FFFC);
    check("wrap_PCp4", PCplus4_D, 32'h0);

    // Repeated flush in DRAIN: latest target wins.
    apply(0, 0, 1, 0, 32'h300);
    apply(0, 1, 1, 0, 32'h400);
    apply(1, 1, 0, 0, 32'h500);
    check("latest_PC", PC, 32'h400);
    apply(0, 0, 1, 0, 32'h600);

    // Reset while draining.
    #1 rst = 1'b1;
    #1;
    check("rstmid_req", {31'h0, imem.imem_req}, 32'h0);
    check("rstmid_PC", PC, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rel_addr", imem.imem_addr, 32'h0);
    check("rel_req", {31'h0, imem.imem_req}, 32'h1);

    // Table of mixed vectors, checked by the model.
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].r, vecs[i].s, vecs[i].f, 1'b0, vecs[i].pcf);
    end
    check("tbl_PC", PC, 32'h94);
    apply(1, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 PC_F  in  32  next-PC value from the next-address selector.
REQ-006 stall_F  in  1  hazard unit: hold IF/ID and PC.
REQ-007 flush_D  in  1  branch/jump taken: kill fetched instruction, redirect to PC_F.
REQ-008 imem_ready  in  1  instruction memory returns data this cycle.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-010 imem_req  out  1  fetch request; held until imem_ready.
REQ-011 imem_addr  out  32  fetch address; equals PC.
REQ-012 PC  out  32  current fetch PC.
REQ-013 PCnext  out  32  PC+4, combinational, to next-address selector.
REQ-014 instr_D, PC_D, PCplus4_D  out  32 each  IF/ID register contents.
REQ-015 valid_D  out  1  IF/ID holds a real instruction.

Function
REQ-016 States: FETCH (imem_req=1), HOLD (imem_req=0, instruction buffered), DRAIN (imem_req=1, killed request outstanding).
REQ-017 imem_addr shall remain stable while imem_req=1 and imem_ready=0.
REQ-018 PC loads shall write {PC_F[31:2],2'b00}; PCnext = PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 FETCH, ready, !flush, !stall: IF/ID <= {imem_rdata, PC, PC+4}, valid_D=1, PC <= PC_F; stay FETCH.
REQ-020 FETCH, ready, stall, !flush: buffer <= imem_rdata; PC and IF/ID hold; go HOLD.
REQ-021 FETCH, ready, flush: discard imem_rdata; IF/ID <= bubble; PC <= PC_F; stay FETCH.
REQ-022 FETCH, !ready, flush: redirect register <= PC_F; IF/ID <= bubble; go DRAIN.
REQ-023 FETCH, !ready, !flush: PC holds; IF/ID <= bubble if !stall, else holds.
REQ-024 HOLD: flush -> bubble, PC <= PC_F, go FETCH; !stall -> IF/ID <= {buffer, PC, PC+4}, valid_D=1, PC <= PC_F, go FETCH; stall -> all hold.
REQ-025 DRAIN: flush reloads redirect register (latest PC_F wins); on ready, discard data, PC <= redirect register, go FETCH; IF/ID <= bubble unless stall.
REQ-026 Bubble = {NOP_INSTR, 0, 0}, valid_D=0.
REQ-027 Precedence: rst > flush_D > stall_F > normal advance.
REQ-028 Latency: instruction returned with imem_ready in cycle N appears on IF/ID outputs in cycle N+1 when not stalled.

Reset
REQ-029 On rst: PC=RESET_PC, state=FETCH, instr_D=NOP_INSTR, PC_D=0, PCplus4_D=0, valid_D=0, buffer=0, redirect register=0.
REQ-030 imem_req shall be 0 while rst=1; rst mid-transaction abandons it; first request after release uses RESET_PC.

Structure
REQ-031 Shared package riscv_pkg holds NOP_INSTR, default RESET_PC, and fetch state enum.
REQ-032 IF/ID register in sub-module if_id_reg (load, bubble, hold controls); FSM, PC, buffer and redirect register in fetch_stage.

Verification
REQ-033 Reset release, ready=1 always, PC_F=PCnext -> imem_addr 0,4,8; instr_D follows one cycle later, valid_D=1.
REQ-034 ready=1, stall_F=1 on fetch at PC=0x8 -> state HOLD, imem_req=0, PC=0x8; stall drop -> instr_D=buffered word, PC_D=0x8, PC=0xC.
REQ-035 FETCH at 0x10, ready=0, flush_D=1, PC_F=0x100 -> DRAIN, addr stays 0x10; ready next cycle -> data dropped, next imem_addr=0x100, valid_D=0.
REQ-036 Simultaneous stall_F=1, flush_D=1, ready=1 -> flush wins: valid_D=0, instr_D=0x13, PC=PC_F.
REQ-037 PC=0xFFFF_FFFC -> PCnext=0x0; PC_F=0x103 -> PC=0x100; rst asserted in DRAIN -> PC=RESET_PC, imem_req=0 immediately.
